// File: rtl/plic_target_arbiter_if.sv
// Bundle of signals between one PLIC target arbiter, the per-source gateways and
// the target's claim/complete register port.
//   master : gateways/target side (drives pending, enables, priorities, requests)
//   slave  : arbiter side (drives interrupt request, best ID and strobes)
interface plic_target_arbiter_if #(
  parameter int unsigned SOURCES    = 8,
  parameter int unsigned PRIORITIES = 7
);
  localparam int unsigned PB  = $clog2(PRIORITIES + 1);
  localparam int unsigned IDB = $clog2(SOURCES + 1);

  logic [SOURCES-1:0]    ip;
  logic [SOURCES-1:0]    ie;
  logic [SOURCES*PB-1:0] prio;
  logic [PB-1:0]         threshold;
  logic                  claim_req;
  logic                  claim_ack;
  logic [IDB-1:0]        claim_id;
  logic                  complete_req;
  logic [IDB-1:0]        complete_id;
  logic [SOURCES-1:0]    gw_claim;
  logic [SOURCES-1:0]    gw_complete;
  logic                  ireq;
  logic [IDB-1:0]        id;

  modport master (
    output ip, ie, prio, threshold, claim_req, complete_req, complete_id,
    input  claim_ack, claim_id, gw_claim, gw_complete, ireq, id
  );

  modport slave (
    input  ip, ie, prio, threshold, claim_req, complete_req, complete_id,
    output claim_ack, claim_id, gw_claim, gw_complete, ireq, id
  );
endinterface

// File: rtl/plic_target_arbiter.sv
// Per-target PLIC arbiter and claim/complete sequencer.
// Picks the highest-priority enabled, pending, unclaimed source whose priority is
// strictly above the target threshold (lowest ID wins ties), and turns the
// target's claim/complete accesses into one-hot single-cycle gateway strobes.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport of plic_target_arbiter_if (ip/ie/prio/threshold,
//            claim and complete handshakes, gateway strobes, ireq/id)
module plic_target_arbiter #(
  parameter int unsigned SOURCES    = 8,
  parameter int unsigned PRIORITIES = 7
) (
  input logic                   clk,
  input logic                   rst_n,
  plic_target_arbiter_if.slave  bus
);
  localparam int unsigned PB  = $clog2(PRIORITIES + 1);
  localparam int unsigned IDB = $clog2(SOURCES + 1);

  logic [SOURCES-1:0] claimed_q, claimed_d;
  logic [SOURCES-1:0] gw_claim_q, gw_claim_d;
  logic [SOURCES-1:0] gw_complete_q, gw_complete_d;
  logic [IDB-1:0]     id_q, id_d;
  logic               ireq_q;
  logic               claim_ack_q;
  logic [IDB-1:0]     claim_id_q;

  logic [SOURCES-1:0] eligible;
  logic [PB-1:0]      best_prio;
  logic [PB-1:0]      prio_i;

  // Claim/complete bookkeeping. A complete only counts against a bit that was
  // already claimed; a same-cycle claim can never hit that ID because claimed
  // IDs are never selected.
  always_comb begin
    claimed_d     = claimed_q;
    gw_claim_d    = '0;
    gw_complete_d = '0;
    for (int i = 0; i < int'(SOURCES); i++) begin
      if (bus.claim_req && (id_q == IDB'(i + 1))) begin
        claimed_d[i]  = 1'b1;
        gw_claim_d[i] = 1'b1;
      end
      if (bus.complete_req && (bus.complete_id == IDB'(i + 1)) && claimed_q[i]) begin
        claimed_d[i]     = 1'b0;
        gw_complete_d[i] = 1'b1;
      end
    end
  end

  // Arbitration against the post-update claimed mask, so a back-to-back claim
  // never sees the ID it just took. Ascending scan with strict '>' keeps the
  // lowest ID on a priority tie.
  always_comb begin
    eligible  = '0;
    best_prio = '0;
    prio_i    = '0;
    id_d      = '0;
    for (int i = 0; i < int'(SOURCES); i++) begin
      prio_i      = bus.prio[i*PB +: PB];
      eligible[i] = bus.ip[i] & bus.ie[i] & ~claimed_d[i] & (prio_i > bus.threshold);
      if (eligible[i] && (prio_i > best_prio)) begin
        best_prio = prio_i;
        id_d      = IDB'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      claimed_q     <= '0;
      gw_claim_q    <= '0;
      gw_complete_q <= '0;
      id_q          <= '0;
      ireq_q        <= 1'b0;
      claim_ack_q   <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      claimed_q     <= claimed_d;
      gw_claim_q    <= gw_claim_d;
      gw_complete_q <= gw_complete_d;
      id_q          <= id_d;
      ireq_q        <= (id_d != '0);
      claim_ack_q   <= bus.claim_req;
      claim_id_q    <= bus.claim_req ? id_q : '0;
    end
  end

  assign bus.claim_ack   = claim_ack_q;
  assign bus.claim_id    = claim_id_q;
  assign bus.gw_claim    = gw_claim_q;
  assign bus.gw_complete = gw_complete_q;
  assign bus.ireq        = ireq_q;
  assign bus.id          = id_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
module tb_plic_target_arbiter;
  localparam int unsigned SOURCES    = 8;
  localparam int unsigned PRIORITIES = 7;

  // prio packing: ID1=3, ID2=5, ID3=5  -> 3 + 5*8 + 5*64
  localparam logic [23:0] P = 24'd363;
  // prio packing: ID1=3, ID2=5, ID3=6  -> 3 + 5*8 + 6*64
  localparam logic [23:0] Q = 24'd427;

  logic clk;
  logic rst_n;

  plic_target_arbiter_if #(.SOURCES(SOURCES), .PRIORITIES(PRIORITIES)) bus ();

  plic_target_arbiter #(.SOURCES(SOURCES), .PRIORITIES(PRIORITIES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ip;
    logic [7:0]  ie;
    logic [23:0] prio;
    logic [2:0]  thr;
    logic        clm;
    logic        cmp;
    logic [3:0]  cmp_id;
    logic [3:0]  e_id;
    logic        e_ireq;
    logic        e_ack;
    logic [3:0]  e_cid;
    logic [7:0]  e_gwc;
    logic [7:0]  e_gwp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [7:0] ip, input logic [7:0] ie, input logic [23:0] prio,
                     input logic [2:0] thr, input logic clm, input logic cmp,
                     input logic [3:0] cmp_id, input logic [3:0] e_id, input logic e_ireq,
                     input logic e_ack, input logic [3:0] e_cid, input logic [7:0] e_gwc,
                     input logic [7:0] e_gwp);
    vec_t v;
    v.ip = ip; v.ie = ie; v.prio = prio; v.thr = thr; v.clm = clm; v.cmp = cmp;
    v.cmp_id = cmp_id; v.e_id = e_id; v.e_ireq = e_ireq; v.e_ack = e_ack;
    v.e_cid = e_cid; v.e_gwc = e_gwc; v.e_gwp = e_gwp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] e_id, input logic e_ireq,
                       input logic e_ack, input logic [3:0] e_cid, input logic [7:0] e_gwc,
                       input logic [7:0] e_gwp);
    checks++;
    if (bus.id !== e_id || bus.ireq !== e_ireq || bus.claim_ack !== e_ack ||
        bus.claim_id !== e_cid || bus.gw_claim !== e_gwc || bus.gw_complete !== e_gwp) begin
      errors++;
      $display("FAIL %s: got id=%0d ireq=%0b ack=%0b cid=%0d gwc=%02h gwp=%02h want id=%0d ireq=%0b ack=%0b cid=%0d gwc=%02h gwp=%02h",
               name, bus.id, bus.ireq, bus.claim_ack, bus.claim_id, bus.gw_claim,
               bus.gw_complete, e_id, e_ireq, e_ack, e_cid, e_gwc, e_gwp);
    end
  endtask

  initial begin
    //   ip     ie     prio thr   clm   cmp   cid    id     irq   ack   cid    gwc    gwp
    add(8'h07, 8'h00, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, P, 3'd5, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, P, 3'd2, 1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1, 4'd2, 8'h02, 8'h00);
    add(8'h05, 8'h07, P, 3'd2, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 4'd3, 8'h04, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h02);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b1, 4'd9, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h03, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h01, 8'h07, P, 3'd2, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd1, 8'h01, 8'h04);
    add(8'h01, 8'h07, P, 3'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h00, P, 3'd2, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h01);
    add(8'h07, 8'h07, P, 3'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, Q, 3'd3, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h03, Q, 3'd3, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h03, Q, 3'd5, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    add(8'h07, 8'h07, Q, 3'd5, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);

    // Reset with everything pending and enabled: outputs must stay quiet.
    rst_n            = 1'b0;
    bus.ip           = 8'hff;
    bus.ie           = 8'hff;
    bus.prio         = P;
    bus.threshold    = 3'd0;
    bus.claim_req    = 1'b0;
    bus.complete_req = 1'b0;
    bus.complete_id  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      if (k != 0) @(negedge clk);
      bus.ip           = vecs[k].ip;
      bus.ie           = vecs[k].ie;
      bus.prio         = vecs[k].prio;
      bus.threshold    = vecs[k].thr;
      bus.claim_req    = vecs[k].clm;
      bus.complete_req = vecs[k].cmp;
      bus.complete_id  = vecs[k].cmp_id;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].e_id, vecs[k].e_ireq, vecs[k].e_ack,
            vecs[k].e_cid, vecs[k].e_gwc, vecs[k].e_gwp);
    end

    // Reset asserted while a claim strobe is out: strobes drop at once and the
    // claimed mask is wiped, so ID2 is offered again afterwards.
    @(negedge clk);
    bus.ip = 8'h07; bus.ie = 8'h07; bus.prio = P; bus.threshold = 3'd2;
    bus.claim_req = 1'b0; bus.complete_req = 1'b0; bus.complete_id = 4'd0;
    @(posedge clk);
    #1;
    check("pre_claim", 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    bus.claim_req = 1'b1;
    @(posedge clk);
    #1;
    check("claim_before_rst", 4'd3, 1'b1, 1'b1, 4'd2, 8'h02, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.claim_req = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst", 4'd2, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/plic_target_arbiter.md
# plic_target_arbiter

Per-target interrupt arbiter and claim/complete sequencer for the PLIC. It sits between the bank of per-source gateways and one interrupt target (hart context). It selects the highest-priority enabled pending source above the target threshold and drives the target's interrupt request. It also routes the target's claim and complete operations back to the gateways as single-cycle strobes.

## Interface
- SOURCES, 8: number of interrupt sources (≥1). Source index i has interrupt ID i+1; ID 0 means "no interrupt".
- PRIORITIES, 7: highest priority level. Width PB = $clog2(PRIORITIES+1); width IDB = $clog2(SOURCES+1).
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  system clock, rising edge
- ip  in  SOURCES  pending bits from the gateways
- ie  in  SOURCES  per-source enable for this target
- prio  in  SOURCES*PB  source priorities; source i at [i*PB +: PB]; 0 = never interrupts
- threshold  in  PB  target priority threshold
- claim_req  in  1  claim strobe (claim register read)
- claim_ack  out  1  claim response strobe
- claim_id  out  IDB  claimed ID, valid with claim_ack
- complete_req  in  1  complete strobe (claim register write)
- complete_id  in  IDB  ID being completed
- gw_claim  out  SOURCES  one-hot claim strobe to the gateways
- gw_complete  out  SOURCES  one-hot complete strobe to the gateways
- ireq  out  1  interrupt request to the target
- id  out  IDB  current best ID (0 if none)

## Operation
- Internal state: claimed[SOURCES] mask, plus registered id, ireq, claim_ack, claim_id, gw_claim and gw_complete.
- Reset: all outputs 0 and claimed = 0.
- Claim, on claim_req:
  - claim_id <= id; claim_ack <= 1.
  - If id ≠ 0: gw_claim[id-1] <= 1 and claimed[id-1] <= 1.
  - If id = 0: claim_id = 0 and no gw_claim pulse.
- Complete, on complete_req with 1 ≤ complete_id ≤ SOURCES and claimed[complete_id-1] = 1: gw_complete[complete_id-1] <= 1 and claimed[complete_id-1] <= 0.
- Any other complete (ID 0, ID out of range, ID not claimed) is silently ignored: no strobe, no state change.
- nxt_claimed is the claimed mask after this cycle's claim and complete updates.
- eligible[i] = ip[i] & ie[i] & ~nxt_claimed[i] & (prio[i] > threshold). The comparison is strict and unsigned.
- Selection: among eligible sources, the highest prio wins; on a tie, the lowest ID wins.
- id <= winner ID, or 0 if no source is eligible; ireq <= (winner ≠ 0).
- Simultaneous claim and complete in one cycle are both processed. They cannot target the same ID, because a claimed ID is never selected.
- claim_ack, gw_claim and gw_complete are single-cycle strobes; they default to 0 every cycle.
- The claimed mask is independent of ie. Disabling a claimed source does not clear its claimed bit; only its complete does.
- Reset asserted mid-operation clears claimed and all strobes immediately. The gateways are reset by the same rst_n.

## Timing
- Arbitration latency is 1 cycle: an input change (ip/ie/prio/threshold) sampled at edge N is reflected in id/ireq after edge N.
- Claim latency is 1 cycle: claim_req high in cycle N gives claim_ack, claim_id and gw_claim high in cycle N+1.
- The id registered at edge N already excludes an ID claimed in cycle N. A back-to-back claim_req in cycle N+1 therefore returns the next-best ID, never a duplicate.
- Complete latency is 1 cycle: complete_req in cycle N gives gw_complete in cycle N+1. The source becomes selectable again from the same edge, once its gateway re-asserts ip.
- The gateway lowers ip one cycle after gw_claim; the claimed mask covers that gap.
- No backpressure: claim_req and complete_req are accepted every cycle.

## Test plan
- Reset: hold rst_n=0 with ip=all ones → all outputs 0. Release with ie=0 → ireq stays 0, id=0.
- Priority and tie-break: prio = {1:3, 2:5, 3:5}, threshold=2, ip/ie set for IDs 1–3 → id=2, ireq=1. Set threshold=5 → id=0, ireq=0 one cycle later.
- Claim: with id=2, pulse claim_req → next cycle claim_ack=1, claim_id=2, gw_claim=0b0010, id=3. A second claim in the following cycle → claim_id=3, id=1.
- Complete: complete_id=2 → gw_complete=0b0010 one cycle later, claimed[1] cleared. Repeat complete_id=2 → no strobe. complete_id=0 and complete_id=SOURCES+1 → no strobe.
- Empty claim: no eligible source, claim_req → claim_ack=1, claim_id=0, gw_claim=0.
- Simultaneous and reset: claim_req (id=1) with complete_req(3) in the same cycle → gw_claim bit0 and gw_complete bit2 together. Assert rst_n mid-claim → claimed=0 and strobes drop asynchronously.
